// File: rtl/l2_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Purpose : shared types and helpers for the L2 port arbiter and its
//           round-robin picker.
// Contents: arb_state_t    - arbiter FSM states
//           ARB_MAX_PORTS  - largest supported requester count
//           ARB_IDX_W      - index width able to address ARB_MAX_PORTS
//           rr_next()      - round-robin winner search
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int unsigned ARB_MAX_PORTS = 8;
  localparam int unsigned ARB_IDX_W     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // First set bit of mask scanning last+1, last+2, ... modulo ports.
  // The loop bound is fixed so the search unrolls to a constant-depth mux tree.
  function automatic logic [ARB_IDX_W-1:0] rr_next(
    input logic [ARB_MAX_PORTS-1:0] mask,
    input logic [ARB_IDX_W-1:0]     last,
    input int unsigned              ports
  );
    logic [ARB_IDX_W-1:0] win;
    logic                 found;
    int unsigned          idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= ARB_MAX_PORTS; i++) begin
      idx = (32'(last) + i) % ports;
      if ((i <= ports) && !found && mask[idx[ARB_IDX_W-1:0]]) begin
        win   = idx[ARB_IDX_W-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/l2_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// l2_port_arbiter_if
// Purpose : bundles the requester-side and downstream memory-side signals of
//           the L2 port arbiter.
// Modports: master - the environment (requesters + downstream memory)
//           slave  - the arbiter
// Signals : req_valid/we/ce/addr/mask/data  per-port requests (flattened)
//           req_ready/req_rdata             one-hot response pulse + shared data
//           mem_valid/we/ce/addr/mask/data  downstream request
//           mem_ready/mem_rdata             downstream completion + read data
//           grant_id                        current owner of the channel
// -----------------------------------------------------------------------------
interface l2_port_arbiter_if #(
  parameter int unsigned PORTS      = 2,
  parameter int unsigned PORT_WIDTH = (PORTS > 1) ? $clog2(PORTS) : 1,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WIDTH      = 128,
  parameter int unsigned MASKW      = WIDTH / 8
);

  logic [PORTS-1:0]            req_valid;
  logic [PORTS-1:0]            req_we;
  logic [PORTS-1:0]            req_ce;
  logic [PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [PORTS*MASKW-1:0]      req_mask;
  logic [PORTS*WIDTH-1:0]      req_data;
  logic [PORTS-1:0]            req_ready;
  logic [WIDTH-1:0]            req_rdata;

  logic                        mem_valid;
  logic                        mem_we;
  logic                        mem_ce;
  logic [ADDR_WIDTH-1:0]       mem_addr;
  logic [MASKW-1:0]            mem_mask;
  logic [WIDTH-1:0]            mem_data;
  logic                        mem_ready;
  logic [WIDTH-1:0]            mem_rdata;

  logic [PORT_WIDTH-1:0]       grant_id;

  modport master (
    output req_valid, req_we, req_ce, req_addr, req_mask, req_data,
    input  req_ready, req_rdata,
    input  mem_valid, mem_we, mem_ce, mem_addr, mem_mask, mem_data,
    output mem_ready, mem_rdata,
    input  grant_id
  );

  modport slave (
    input  req_valid, req_we, req_ce, req_addr, req_mask, req_data,
    output req_ready, req_rdata,
    output mem_valid, mem_we, mem_ce, mem_addr, mem_mask, mem_data,
    input  mem_ready, mem_rdata,
    output grant_id
  );

endinterface

// File: rtl/l2_port_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purpose : combinational round-robin picker, reusable wherever a set of
//           requesters shares one resource.
// Ports   : mask_i      request mask, bit i = requester i wants the resource
//           last_i      index granted most recently
//           any_valid_c at least one mask bit set (combinational)
//           winner_c    first requester after last_i, modulo PORTS (combinational)
// -----------------------------------------------------------------------------
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned PORTS      = 2,
  parameter int unsigned PORT_WIDTH = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic [PORTS-1:0]      mask_i,
  input  logic [PORT_WIDTH-1:0] last_i,
  output logic                  any_valid_c,
  output logic [PORT_WIDTH-1:0] winner_c
);

  logic [ARB_MAX_PORTS-1:0] mask_ext;
  logic [ARB_IDX_W-1:0]     last_ext;

  assign mask_ext    = ARB_MAX_PORTS'(mask_i);
  assign last_ext    = ARB_IDX_W'(last_i);
  assign any_valid_c = |mask_i;
  assign winner_c    = PORT_WIDTH'(rr_next(mask_ext, last_ext, PORTS));

endmodule

// File: rtl/l2_port_arbiter.sv
// -----------------------------------------------------------------------------
// l2_port_arbiter
// Purpose : funnels PORTS requesters onto one downstream memory channel.
//           A winner is chosen by round robin, its request is latched and
//           held on mem_* until mem_ready, then a one-cycle req_ready pulse
//           returns the latched mem_rdata to that requester.
// Ports   : clk  - clock
//           rst  - synchronous active-high reset
//           bus  - l2_port_arbiter_if slave modport (requests, responses,
//                  downstream channel, grant_id)
// Config  : ARB_WRITE_FIRST_EN - when defined, pending writes win arbitration
//           over reads; otherwise pure round robin.
// -----------------------------------------------------------------------------
module l2_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned PORTS      = 2,
  parameter int unsigned PORT_WIDTH = (PORTS > 1) ? $clog2(PORTS) : 1,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WIDTH      = 128,
  parameter int unsigned MASKW      = WIDTH / 8
) (
  input logic               clk,
  input logic               rst,
  l2_port_arbiter_if.slave  bus
);

  arb_state_t            state_q,      state_d;
  logic [PORT_WIDTH-1:0] last_grant_q, last_grant_d;
  logic [PORT_WIDTH-1:0] grant_q,      grant_d;
  logic                  mem_valid_q,  mem_valid_d;
  logic                  we_q,         we_d;
  logic                  ce_q,         ce_d;
  logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
  logic [MASKW-1:0]      mask_q,       mask_d;
  logic [WIDTH-1:0]      data_q,       data_d;
  logic [WIDTH-1:0]      rdata_q,      rdata_d;
  logic [PORTS-1:0]      ready_q,      ready_d;

  logic [PORTS-1:0]      pick_mask;
  logic                  any_valid;
  logic [PORT_WIDTH-1:0] winner;
  int unsigned           sel;

  // Candidate set for arbitration.
`ifdef ARB_WRITE_FIRST_EN
  logic [PORTS-1:0] wr_mask;
  assign wr_mask = bus.req_valid & bus.req_we;
  always_comb begin
    pick_mask = bus.req_valid;
    if (|wr_mask) pick_mask = wr_mask;
  end
`else
  always_comb begin
    pick_mask = bus.req_valid;
  end
`endif

  rr_pick #(
    .PORTS      (PORTS),
    .PORT_WIDTH (PORT_WIDTH)
  ) u_rr_pick (
    .mask_i      (pick_mask),
    .last_i      (last_grant_q),
    .any_valid_c (any_valid),
    .winner_c    (winner)
  );

  assign sel = 32'(winner);

  // State and payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_WIDTH'(PORTS - 1);
      grant_q      <= '0;
      mem_valid_q  <= 1'b0;
      we_q         <= 1'b0;
      ce_q         <= 1'b0;
      addr_q       <= '0;
      mask_q       <= '0;
      data_q       <= '0;
      rdata_q      <= '0;
      ready_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      mem_valid_q  <= mem_valid_d;
      we_q         <= we_d;
      ce_q         <= ce_d;
      addr_q       <= addr_d;
      mask_q       <= mask_d;
      data_q       <= data_d;
      rdata_q      <= rdata_d;
      ready_q      <= ready_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    mem_valid_d  = mem_valid_q;
    we_d         = we_q;
    ce_d         = ce_q;
    addr_d       = addr_q;
    mask_d       = mask_q;
    data_d       = data_q;
    rdata_d      = rdata_q;
    ready_d      = '0;

    case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_d     = winner;
          we_d        = bus.req_we[winner];
          ce_d        = bus.req_ce[winner];
          addr_d      = bus.req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
          mask_d      = bus.req_mask[sel*MASKW +: MASKW];
          data_d      = bus.req_data[sel*WIDTH +: WIDTH];
          mem_valid_d = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        // Requester valid is not looked at here: a latched request always completes.
        if (bus.mem_ready) begin
          rdata_d           = bus.mem_rdata;
          last_grant_d      = grant_q;
          mem_valid_d       = 1'b0;
          ready_d[grant_q]  = 1'b1;
          state_d           = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_ce    = ce_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_mask  = mask_q;
  assign bus.mem_data  = data_q;
  assign bus.req_ready = ready_q;
  assign bus.req_rdata = rdata_q;
  assign bus.grant_id  = grant_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_l2_port_arbiter
// Purpose : directed self-checking bench for l2_port_arbiter with two ports.
//           Inputs change on the falling edge; outputs are sampled on the
//           falling edge, half a cycle away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_l2_port_arbiter;

  localparam int unsigned PORTS = 2;
  localparam int unsigned PW    = 1;
  localparam int unsigned AW    = 32;
  localparam int unsigned W     = 128;
  localparam int unsigned MW    = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  l2_port_arbiter_if #(
    .PORTS(PORTS), .PORT_WIDTH(PW), .ADDR_WIDTH(AW), .WIDTH(W), .MASKW(MW)
  ) bus ();

  l2_port_arbiter #(
    .PORTS(PORTS), .PORT_WIDTH(PW), .ADDR_WIDTH(AW), .WIDTH(W), .MASKW(MW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_ce    = '0;
    bus.req_addr  = '0;
    bus.req_mask  = '0;
    bus.req_data  = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_req(input int p, input logic we, input logic ce, input logic [AW-1:0] a,
                         input logic [MW-1:0] m, input logic [W-1:0] d);
    bus.req_we[p]          = we;
    bus.req_ce[p]          = ce;
    bus.req_addr[p*AW +: AW] = a;
    bus.req_mask[p*MW +: MW] = m;
    bus.req_data[p*W +: W]   = d;
    bus.req_valid[p]       = 1'b1;
  endtask

  task automatic drop_req(input int p);
    bus.req_valid[p] = 1'b0;
  endtask

  // Bounded wait (on falling edges) for the downstream request to appear.
  task automatic wait_mem_valid(output logic ok);
    int n;
    n = 0;
    while (bus.mem_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.mem_valid === 1'b1);
  endtask

  // Completion presented on a falling edge, removed after the next rising edge.
  task automatic give_ready(input logic [W-1:0] rd);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = rd;
    @(posedge clk);
    #1 bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (3) @(negedge clk);
    n_checks++; if (bus.mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid got %b want 0", bus.mem_valid); end
    n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got %b want 00", bus.req_ready); end
    n_checks++; if (bus.grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_grant_id got %b want 0", bus.grant_id); end
    n_checks++; if (bus.req_rdata !== '0) begin n_fail++; $display("FAIL reset_req_rdata got %h want 0", bus.req_rdata); end
    n_checks++; if ({bus.mem_we, bus.mem_ce, bus.mem_addr} !== '0) begin n_fail++; $display("FAIL reset_mem_fields got %h want 0", {bus.mem_we, bus.mem_ce, bus.mem_addr}); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.mem_valid !== 1'b0) begin n_fail++; $display("FAIL idle_no_req got %b want 0", bus.mem_valid); end
  endtask

  task automatic test_single_read();
    set_req(1, 1'b0, 1'b0, 32'h100, '1, '0);
    @(negedge clk);
    n_checks++; if (bus.mem_valid !== 1'b1) begin n_fail++; $display("FAIL rd_mem_valid got %b want 1", bus.mem_valid); end
    n_checks++; if (bus.mem_addr !== 32'h100) begin n_fail++; $display("FAIL rd_mem_addr got %h want 100", bus.mem_addr); end
    n_checks++; if (bus.grant_id !== 1'b1) begin n_fail++; $display("FAIL rd_grant got %b want 1", bus.grant_id); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rd_mem_we got %b want 0", bus.mem_we); end
    repeat (2) @(negedge clk);
    n_checks++; if (bus.mem_valid !== 1'b1 || bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL rd_wait valid=%b ready=%b want 1/00", bus.mem_valid, bus.req_ready); end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 128'hDEADBEEF;
    @(posedge clk);
    #1 bus.mem_ready = 1'b0;
    drop_req(1);
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL rd_ready got %b want 10", bus.req_ready); end
    n_checks++; if (bus.req_rdata !== 128'hDEADBEEF) begin n_fail++; $display("FAIL rd_rdata got %h want deadbeef", bus.req_rdata); end
    n_checks++; if (bus.mem_valid !== 1'b0) begin n_fail++; $display("FAIL rd_resp_valid got %b want 0", bus.mem_valid); end
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL rd_pulse_len got %b want 00", bus.req_ready); end
    n_checks++; if (bus.req_rdata !== 128'hDEADBEEF) begin n_fail++; $display("FAIL rd_rdata_hold got %h want deadbeef", bus.req_rdata); end
  endtask

  task automatic test_contention();
    logic       ok;
    logic [0:0] exp;
    exp = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'h200, '1, '0);
    set_req(1, 1'b0, 1'b0, 32'h300, '1, '0);
    for (int k = 0; k < 4; k++) begin
      wait_mem_valid(ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL cont_timeout txn %0d got %b want 1", k, ok); end
      n_checks++; if (bus.grant_id !== exp) begin n_fail++; $display("FAIL cont_grant txn %0d got %b want %b", k, bus.grant_id, exp); end
      n_checks++; if (bus.mem_addr !== (exp ? 32'h300 : 32'h200)) begin n_fail++; $display("FAIL cont_addr txn %0d got %h", k, bus.mem_addr); end
      @(negedge clk);
      give_ready(W'(k + 16));
      @(negedge clk);
      n_checks++; if (bus.req_ready !== (exp ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL cont_ready txn %0d got %b want onehot %0d", k, bus.req_ready, exp); end
      n_checks++; if (bus.req_rdata !== W'(k + 16)) begin n_fail++; $display("FAIL cont_rdata txn %0d got %h want %h", k, bus.req_rdata, W'(k + 16)); end
      @(negedge clk);
      n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL cont_pulse txn %0d got %b want 00", k, bus.req_ready); end
      exp = ~exp;
    end
    drop_req(0);
    drop_req(1);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_priority();
    logic ok;
    do_reset();
    set_req(0, 1'b0, 1'b0, 32'h10, '1, '0);
    set_req(1, 1'b0, 1'b0, 32'h20, '1, '0);
    wait_mem_valid(ok);
    n_checks++; if (ok !== 1'b1 || bus.grant_id !== 1'b0) begin n_fail++; $display("FAIL prio_first ok=%b grant=%b want 1/0", ok, bus.grant_id); end
    // completion in the very first REQ cycle
    give_ready(128'h1);
    drop_req(0);
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL prio_ready0 got %b want 01", bus.req_ready); end
    wait_mem_valid(ok);
    n_checks++; if (ok !== 1'b1 || bus.grant_id !== 1'b1) begin n_fail++; $display("FAIL prio_second ok=%b grant=%b want 1/1", ok, bus.grant_id); end
    give_ready(128'h2);
    drop_req(1);
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL prio_ready1 got %b want 10", bus.req_ready); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_payload();
    logic ok;
    set_req(0, 1'b1, 1'b1, 32'h40, 16'h000F, 128'h1234);
    wait_mem_valid(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wr_timeout got %b want 1", ok); end
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({bus.mem_valid, bus.mem_we, bus.mem_ce} !== 3'b111 || bus.mem_mask !== 16'h000F ||
          bus.mem_data !== 128'h1234 || bus.mem_addr !== 32'h40) begin
        n_fail++;
        $display("FAIL wr_payload cycle %0d got v/we/ce=%b mask=%h data=%h addr=%h want 111/000f/1234/40",
                 c, {bus.mem_valid, bus.mem_we, bus.mem_ce}, bus.mem_mask, bus.mem_data, bus.mem_addr);
      end
      if (c < 2) @(negedge clk);
    end
    give_ready(128'hFFFF);
    drop_req(0);
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL wr_ready got %b want 01", bus.req_ready); end
    n_checks++; if (bus.req_rdata !== 128'hFFFF) begin n_fail++; $display("FAIL wr_rdata got %h want ffff", bus.req_rdata); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ignored_inputs();
    logic ok;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 128'hBAD;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    n_checks++; if (bus.req_ready !== 2'b00 || bus.mem_valid !== 1'b0) begin n_fail++; $display("FAIL idle_mem_ready ready=%b valid=%b want 00/0", bus.req_ready, bus.mem_valid); end
    n_checks++; if (bus.req_rdata !== 128'hFFFF) begin n_fail++; $display("FAIL idle_rdata got %h want ffff", bus.req_rdata); end
    set_req(1, 1'b0, 1'b0, 32'h500, '1, '0);
    wait_mem_valid(ok);
    drop_req(1);
    @(negedge clk);
    n_checks++; if (ok !== 1'b1 || bus.mem_valid !== 1'b1) begin n_fail++; $display("FAIL drop_hold ok=%b valid=%b want 1/1", ok, bus.mem_valid); end
    give_ready(128'hA5);
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 2'b10 || bus.req_rdata !== 128'hA5) begin n_fail++; $display("FAIL drop_ready got %b/%h want 10/a5", bus.req_ready, bus.req_rdata); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_req();
    logic ok;
    logic seen;
    set_req(0, 1'b1, 1'b1, 32'h700, 16'hFFFF, 128'h77);
    wait_mem_valid(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mid_timeout got %b want 1", ok); end
    rst = 1'b1;
    drop_req(0);
    @(negedge clk);
    n_checks++; if (bus.mem_valid !== 1'b0 || bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL mid_outputs valid=%b ready=%b want 0/00", bus.mem_valid, bus.req_ready); end
    n_checks++; if ({bus.mem_we, bus.mem_ce, bus.mem_addr, bus.mem_data, bus.req_rdata} !== '0) begin n_fail++; $display("FAIL mid_fields nonzero addr=%h rdata=%h", bus.mem_addr, bus.req_rdata); end
    rst = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.req_ready !== 2'b00) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_no_ready got %b want 0", seen); end
    set_req(1, 1'b0, 1'b0, 32'h800, '1, '0);
    wait_mem_valid(ok);
    n_checks++; if (ok !== 1'b1 || bus.grant_id !== 1'b1 || bus.mem_addr !== 32'h800) begin n_fail++; $display("FAIL mid_next ok=%b grant=%b addr=%h want 1/1/800", ok, bus.grant_id, bus.mem_addr); end
    give_ready(128'h88);
    drop_req(1);
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 2'b10 || bus.req_rdata !== 128'h88) begin n_fail++; $display("FAIL mid_next_ready got %b/%h want 10/88", bus.req_ready, bus.req_rdata); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_first();
    logic       ok;
    logic [0:0] first;
`ifdef ARB_WRITE_FIRST_EN
    first = 1'b1;
`else
    first = 1'b0;
`endif
    do_reset();
    set_req(0, 1'b0, 1'b0, 32'h900, '1, '0);
    set_req(1, 1'b1, 1'b0, 32'hA00, '1, 128'h55);
    wait_mem_valid(ok);
    n_checks++; if (ok !== 1'b1 || bus.grant_id !== first) begin n_fail++; $display("FAIL wf_first ok=%b grant=%b want 1/%b", ok, bus.grant_id, first); end
    give_ready(128'h3);
    drop_req(int'(first));
    @(negedge clk);
    wait_mem_valid(ok);
    n_checks++; if (ok !== 1'b1 || bus.grant_id !== ~first) begin n_fail++; $display("FAIL wf_second ok=%b grant=%b want 1/%b", ok, bus.grant_id, ~first); end
    give_ready(128'h4);
    drop_req(int'(~first));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_reset_priority();
    test_write_payload();
    test_ignored_inputs();
    test_reset_mid_req();
    test_write_first();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Round-robin arbiter that funnels PORTS independent requesters (L1 I/D caches, DMA) onto one downstream memory request channel, e.g. a single-ported L2 or the memory controller.
- Each request is latched, forwarded until the downstream accepts it, and its response is returned to the winning requester with a one-cycle ready pulse.
- Read and write requests share one queue position per port and are served strictly one at a time.

Parameters:
- PORTS, 2, number of requesters (1..8)
- PORT_WIDTH, (PORTS>1 ? $clog2(PORTS) : 1), grant index width
- ADDR_WIDTH, 32, byte address width
- WIDTH, 128, data width in bits
- MASKW, WIDTH/8, byte-enable width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  PORTS  per-port request valid
- req_we  in  PORTS  per-port write enable (0 = read)
- req_ce  in  PORTS  per-port "invalidate others" flag, forwarded unchanged
- req_addr  in  PORTS*ADDR_WIDTH  flattened addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_mask  in  PORTS*MASKW  flattened byte masks
- req_data  in  PORTS*WIDTH  flattened write data
- req_ready  out  PORTS  one-hot response pulse
- req_rdata  out  WIDTH  read data, shared by all ports, valid with req_ready
- mem_valid  out  1  downstream request valid
- mem_we  out  1  downstream write enable
- mem_ce  out  1  downstream invalidate flag
- mem_addr  out  ADDR_WIDTH  downstream address
- mem_mask  out  MASKW  downstream byte mask
- mem_data  out  WIDTH  downstream write data
- mem_ready  in  1  downstream completion, one cycle
- mem_rdata  in  WIDTH  downstream read data, valid with mem_ready
- grant_id  out  PORT_WIDTH  index of the port currently owning the channel (debug)

Behaviour:
- Clock, reset and synchronicity: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0. State is IDLE. last_grant = PORTS-1, so port 0 has top priority first.
- FSM states are IDLE, REQ and RESP.
- IDLE:
  - If any req_valid is set, pick the winner by round robin: the first valid port scanning last_grant+1, last_grant+2, … modulo PORTS.
  - Latch the winner's we/ce/addr/mask/data into payload registers and its index into grant_id, then go to REQ.
  - With no valid port, stay in IDLE.
- REQ:
  - mem_valid = 1 and mem_* driven from the payload registers, held stable for the whole state.
  - On mem_ready: latch mem_rdata (writes included), set last_grant = grant_id, go to RESP.
  - mem_ready may arrive in the first REQ cycle. Minimum request-to-ready latency is 2 cycles plus downstream latency.
- RESP:
  - req_ready[grant_id] = 1 for exactly one cycle; req_rdata = latched data.
  - Go to IDLE.
  - Outside RESP, req_rdata holds its last value and req_ready = 0.
- Requester rules:
  - Hold req_valid and all fields stable until req_ready is seen.
  - In the cycle after req_ready, deassert req_valid or present a new request. A request still asserted in IDLE is treated as new.
- req_valid dropped while the arbiter is in REQ is ignored. The latched request completes and the ready pulse is still issued.
- mem_ready outside REQ is ignored.
- Fairness: a continuously requesting port waits at most PORTS-1 other transactions.
- Reset mid-transaction: the request is abandoned immediately and mem_valid drops the next cycle. No req_ready is issued. Downstream must tolerate a dropped valid under reset.
- PORTS = 1: degenerates to a registered pass-through; grant_id is always 0.

Optional Feature:
- ARB_WRITE_FIRST_EN
- Defined: in IDLE, if any valid port has req_we = 1, arbitration runs round robin among write requesters only. Reads win only when no write is pending. This avoids read-after-write hazards across ports; read starvation under write flood is accepted.
- Undefined: pure round robin, ignoring req_we.

Decomposition:
- Package arb_pkg:
  - arb_state_t enum (IDLE, REQ, RESP)
  - ARB_MAX_PORTS = 8
  - function rr_next(mask, last) returning the winner index
- Sub-module rr_pick: combinational round-robin picker. Inputs are the request mask and last_grant; outputs are any_valid and winner index. It is reusable by the L2 read/write arbitration.
- Payload registers and FSM stay in l2_port_arbiter.

Test Plan:
- Single read: port 1 read, addr 0x100 → mem_valid with mem_addr 0x100 one cycle after request. mem_ready+mem_rdata=0xDEADBEEF after 3 cycles → req_ready = 2'b10 next cycle with req_rdata 0xDEADBEEF.
- Contention: ports 0 and 1 valid continuously, downstream ready after 1 cycle → grants alternate 0,1,0,1. Each req_ready is a one-cycle pulse.
- Reset priority: ports 0 and 1 assert together right after reset → port 0 served first.
- Write payload: port 0 write, mask 0x000F, data 0x1234, ce = 1 → mem_we = 1, mem_mask 0x000F, mem_ce = 1, all stable until mem_ready; req_ready[0] pulses.
- Reset mid-REQ: assert rst while mem_valid = 1 → all outputs 0 next cycle, no req_ready; the following request from port 1 is served normally.
- ARB_WRITE_FIRST_EN: port 0 read and port 1 write simultaneously → port 1 granted first. Without the macro, port 0 is granted first.
